// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing a 1RW+1R OpenRAM macro between two Wishbone requesters.
// One transaction in flight; writes go out on port B, reads on port A.
module sram_port_arbiter #(
    parameter int unsigned SRAM_ADDR_WD = 8,
    parameter int unsigned SRAM_DATA_WD = 32
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,

    input  logic                      m0_wb_cyc_i,
    input  logic                      m0_wb_stb_i,
    input  logic                      m0_wb_we_i,
    input  logic [SRAM_ADDR_WD-1:0]   m0_wb_adr_i,
    input  logic [SRAM_DATA_WD-1:0]   m0_wb_dat_i,
    input  logic [SRAM_DATA_WD/8-1:0] m0_wb_sel_i,
    output logic [SRAM_DATA_WD-1:0]   m0_wb_dat_o,
    output logic                      m0_wb_ack_o,

    input  logic                      m1_wb_cyc_i,
    input  logic                      m1_wb_stb_i,
    input  logic                      m1_wb_we_i,
    input  logic [SRAM_ADDR_WD-1:0]   m1_wb_adr_i,
    input  logic [SRAM_DATA_WD-1:0]   m1_wb_dat_i,
    input  logic [SRAM_DATA_WD/8-1:0] m1_wb_sel_i,
    output logic [SRAM_DATA_WD-1:0]   m1_wb_dat_o,
    output logic                      m1_wb_ack_o,

    output logic                      sram_csb_a,
    output logic [SRAM_ADDR_WD-1:0]   sram_addr_a,
    input  logic [SRAM_DATA_WD-1:0]   sram_dout_a,

    output logic                      sram_csb_b,
    output logic                      sram_web_b,
    output logic [SRAM_DATA_WD/8-1:0] sram_mask_b,
    output logic [SRAM_ADDR_WD-1:0]   sram_addr_b,
    output logic [SRAM_DATA_WD-1:0]   sram_din_b,

    output logic                      grant_o
);

    localparam int unsigned MASK_WD = SRAM_DATA_WD / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_grant;
    logic                    r_we;
    logic                    r_csb_a;
    logic [SRAM_ADDR_WD-1:0] r_addr_a;
    logic                    r_csb_b;
    logic                    r_web_b;
    logic [MASK_WD-1:0]      r_mask_b;
    logic [SRAM_ADDR_WD-1:0] r_addr_b;
    logic [SRAM_DATA_WD-1:0] r_din_b;
    logic [SRAM_DATA_WD-1:0] r_dat0;
    logic [SRAM_DATA_WD-1:0] r_dat1;
    logic                    r_ack0;
    logic                    r_ack1;

    logic                    w_req0;
    logic                    w_req1;
    logic                    w_pick;
    logic                    w_pick_we;
    logic [SRAM_ADDR_WD-1:0] w_pick_adr;
    logic [SRAM_DATA_WD-1:0] w_pick_dat;
    logic [MASK_WD-1:0]      w_pick_sel;
    logic                    w_gnt_cyc;

    assign w_req0 = m0_wb_cyc_i & m0_wb_stb_i;
    assign w_req1 = m1_wb_cyc_i & m1_wb_stb_i;

    // On contention the requester that was not granted last wins.
    always_comb begin
        w_pick = r_grant;
        if (w_req0 && w_req1) begin
            w_pick = ~r_grant;
        end else if (w_req0) begin
            w_pick = 1'b0;
        end else if (w_req1) begin
            w_pick = 1'b1;
        end
    end

    assign w_pick_we  = w_pick ? m1_wb_we_i  : m0_wb_we_i;
    assign w_pick_adr = w_pick ? m1_wb_adr_i : m0_wb_adr_i;
    assign w_pick_dat = w_pick ? m1_wb_dat_i : m0_wb_dat_i;
    assign w_pick_sel = w_pick ? m1_wb_sel_i : m0_wb_sel_i;
    assign w_gnt_cyc  = r_grant ? m1_wb_cyc_i : m0_wb_cyc_i;

    // Strobes are launched on the grant edge so the macro sees them during ACCESS;
    // ack is decided on the edge entering ACK so an abort in the prior cycle suppresses it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= IDLE;
            r_grant  <= 1'b1;
            r_we     <= 1'b0;
            r_csb_a  <= 1'b1;
            r_addr_a <= '0;
            r_csb_b  <= 1'b1;
            r_web_b  <= 1'b1;
            r_mask_b <= '0;
            r_addr_b <= '0;
            r_din_b  <= '0;
            r_dat0   <= '0;
            r_dat1   <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_grant <= w_pick;
                        r_we    <= w_pick_we;
                        if (w_pick_we) begin
                            r_csb_b  <= 1'b0;
                            r_web_b  <= 1'b0;
                            r_addr_b <= w_pick_adr;
                            r_din_b  <= w_pick_dat;
                            r_mask_b <= w_pick_sel;
                        end else begin
                            r_csb_a  <= 1'b0;
                            r_addr_a <= w_pick_adr;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_csb_a <= 1'b1;
                    r_csb_b <= 1'b1;
                    r_web_b <= 1'b1;
                    if (r_we) begin
                        r_ack0  <= w_gnt_cyc & ~r_grant;
                        r_ack1  <= w_gnt_cyc &  r_grant;
                        r_state <= ACK;
                    end else begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (r_grant) begin
                        r_dat1 <= sram_dout_a;
                    end else begin
                        r_dat0 <= sram_dout_a;
                    end
                    r_ack0  <= w_gnt_cyc & ~r_grant;
                    r_ack1  <= w_gnt_cyc &  r_grant;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m0_wb_dat_o = r_dat0;
    assign m0_wb_ack_o = r_ack0;
    assign m1_wb_dat_o = r_dat1;
    assign m1_wb_ack_o = r_ack1;
    assign sram_csb_a  = r_csb_a;
    assign sram_addr_a = r_addr_a;
    assign sram_csb_b  = r_csb_b;
    assign sram_web_b  = r_web_b;
    assign sram_mask_b = r_mask_b;
    assign sram_addr_b = r_addr_b;
    assign sram_din_b  = r_din_b;
    assign grant_o     = r_grant;

endmodule
